// File: rtl/spi_master_pkg.sv
// spi_master_pkg
// Shared types and constants for the SPI master controller slice.
//   state_t      : controller FSM states
//   OP_*         : 2-bit command opcodes carried in cmd_data[9:8]
//   CMD_W        : command frame width (opcode + payload)
//   DATA_W       : width of the byte returned on MISO
//   SEND_BITS    : MOSI bits per frame (select bit + 10 command bits)
//   seq_illegal  : opcode-ordering rule used when SPI_MASTER_SEQ_CHECK_EN is defined
package spi_master_pkg;

   localparam int CMD_W     = 10;
   localparam int DATA_W    = 8;
   localparam int SEND_BITS = 11;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SEND,
      TURN,
      RECV,
      GAP
   } state_t;

   // A data phase must directly follow its matching address phase.
   function automatic logic seq_illegal(input logic [1:0] op, input logic [1:0] last_op);
      return ((op == OP_WR_DATA) && (last_op != OP_WR_ADDR)) ||
             ((op == OP_RD_DATA) && (last_op != OP_RD_ADDR));
   endfunction

endpackage

// File: rtl/spi_master_ctrl_shift.sv
// spi_shift_unit
// Datapath shifters for the SPI master: a loadable 10-bit PISO feeding MOSI
// and an 8-bit SIPO collecting MISO. Both shift only when the FSM enables them.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_data into the transmit shifter
//   load_data   : command word (opcode + payload)
//   shift_en    : advance the transmit shifter one bit toward the MSB
//   tx_bit      : current MSB of the transmit shifter
//   sample_en   : shift rx_bit into the receive byte
//   rx_bit      : serial input from MISO
//   rx_data     : received byte, MSB first
module spi_shift_unit
   import spi_master_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [CMD_W-1:0]  load_data,
   input  logic              shift_en,
   output logic              tx_bit,
   input  logic              sample_en,
   input  logic              rx_bit,
   output logic [DATA_W-1:0] rx_data
);

   logic [CMD_W-1:0] tx_sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sr <= '0;
      end else if (load) begin
         tx_sr <= load_data;
      end else if (shift_en) begin
         tx_sr <= {tx_sr[CMD_W-2:0], 1'b0};
      end
   end

   assign tx_bit = tx_sr[CMD_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data <= '0;
      end else if (sample_en) begin
         rx_data <= {rx_data[DATA_W-2:0], rx_bit};
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// SPI master that frames 10-bit commands on MOSI under SS_n and, for read-data
// commands, collects the slave's 8-bit reply from MISO.
// Optional feature macro: SPI_MASTER_SEQ_CHECK_EN adds seq_err, flagging a
// data-phase command that does not directly follow its address-phase command.
// Parameters:
//   TURNAROUND : SS_n-low cycles between the last command bit and the first MISO sample (1..15)
//   MIN_GAP    : minimum SS_n-high GAP cycles between frames (1..15)
// Ports:
//   clk, rst_n  : clock (also the SPI bit clock), asynchronous active-low reset
//   cmd_valid / cmd_ready / cmd_data : host command handshake
//   rd_valid, rd_data : one-cycle pulse with the received byte
//   busy        : frame in progress or gap pending
//   SS_n, MOSI, MISO : SPI pins
//   seq_err     : (SPI_MASTER_SEQ_CHECK_EN only) one-cycle ordering error pulse
module spi_master_ctrl
   import spi_master_pkg::*;
#(
   parameter int TURNAROUND = 2,
   parameter int MIN_GAP    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CMD_W-1:0]  cmd_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
`ifdef SPI_MASTER_SEQ_CHECK_EN
   ,
   output logic              seq_err
`endif
);

   localparam logic [3:0] SEND_LAST = 4'(SEND_BITS - 1);
   localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
   localparam logic [3:0] RECV_LAST = 4'(DATA_W - 1);
   localparam logic [3:0] GAP_LAST  = 4'(MIN_GAP - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [1:0] frame_op;
   logic       accept;
   logic       tx_bit;

   assign accept = cmd_valid && cmd_ready;

   spi_shift_unit u_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .load_data (cmd_data),
      .shift_en  (state == SEND),
      .tx_bit    (tx_bit),
      .sample_en (state == RECV),
      .rx_bit    (MISO),
      .rx_data   (rd_data)
   );

   // The first SEND bit is the shifter MSB presented without shifting, so the
   // opcode MSB goes out twice: once as the slave's read/write select and
   // once as the head of the 10-bit command. cnt restarts at every state
   // change and only advances until the state's terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         frame_op  <= OP_WR_ADDR;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  SS_n      <= 1'b0;
                  MOSI      <= 1'b0;
                  frame_op  <= cmd_data[CMD_W-1 -: 2];
                  cnt       <= '0;
                  state     <= SETUP;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            SETUP: begin
               MOSI  <= tx_bit;
               cnt   <= '0;
               state <= SEND;
            end
            SEND: begin
               if (cnt == SEND_LAST) begin
                  MOSI <= 1'b0;
                  cnt  <= '0;
                  if (frame_op == OP_RD_DATA) begin
                     state <= TURN;
                  end else begin
                     SS_n  <= 1'b1;
                     state <= GAP;
                  end
               end else begin
                  MOSI <= tx_bit;
                  cnt  <= cnt + 4'd1;
               end
            end
            TURN: begin
               if (cnt == TURN_LAST) begin
                  cnt   <= '0;
                  state <= RECV;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RECV: begin
               if (cnt == RECV_LAST) begin
                  rd_valid <= 1'b1;
                  SS_n     <= 1'b1;
                  cnt      <= '0;
                  state    <= GAP;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  cnt       <= '0;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SPI_MASTER_SEQ_CHECK_EN
   logic [1:0] last_op;

   // Resetting last_op to OP_RD_DATA makes it a legal predecessor of neither
   // data phase, so a data command straight after reset is always flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_err <= 1'b0;
         last_op <= OP_RD_DATA;
      end else begin
         seq_err <= 1'b0;
         if (accept) begin
            seq_err <= seq_illegal(cmd_data[CMD_W-1 -: 2], last_op);
            last_op <= cmd_data[CMD_W-1 -: 2];
         end
      end
   end
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
// Directed bench for spi_master_ctrl with a small behavioural SPI slave + RAM
// model that decodes MOSI frames and answers read-data frames on MISO.
// Build with SPI_MASTER_SEQ_CHECK_EN defined to also exercise seq_err.
module tb_spi_master_ctrl;

   localparam int TURN = 2;
   localparam int GAPC = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [9:0] cmd_data = '0;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       busy;
   logic       SS_n;
   logic       MOSI;
   logic       MISO = 1'b1;
`ifdef SPI_MASTER_SEQ_CHECK_EN
   logic       seq_err;
`endif

   int total_checks = 0;
   int bad_checks = 0;

   // slave model / monitor state
   logic [7:0]  ram [256];
   logic [7:0]  slave_addr = '0;
   logic [7:0]  rd_byte = '0;
   logic [11:0] rx_bits = '0;
   logic [11:0] last_mosi = '0;
   logic [7:0]  last_rd = '0;
   logic        in_frame = 1'b0;
   int idx = 0;
   int high_count = 0;
   int last_gap = 0;
   int last_frame_len = 0;
   int frame_count = 0;
   int rd_valid_count = 0;
   int rd_valid_pos = 0;
   int ready_violations = 0;
   int accept_count = 0;
   int seq_err_count = 0;
   int seq_err_in_setup = 0;

   spi_master_ctrl #(.TURNAROUND(TURN), .MIN_GAP(GAPC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .busy      (busy),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO)
`ifdef SPI_MASTER_SEQ_CHECK_EN
      ,
      .seq_err   (seq_err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
   end

   always @(posedge clk) begin
      if (cmd_valid && cmd_ready) accept_count++;
   end

   // Slave model: cycle 0 of a frame is SETUP, cycles 1..11 carry the select
   // bit and the command, reply bits occupy cycles 12+TURN .. 19+TURN.
   always @(negedge clk) begin
      if (busy && cmd_ready) ready_violations++;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      if (seq_err) seq_err_count++;
`endif
      if (!SS_n) begin
         if (!in_frame) begin
            in_frame = 1'b1;
            idx = 0;
            last_gap = high_count;
            rx_bits = '0;
         end
`ifdef SPI_MASTER_SEQ_CHECK_EN
         if (seq_err && idx == 0) seq_err_in_setup++;
`endif
         if (idx <= 11) rx_bits = {rx_bits[10:0], MOSI};
         if (idx == 11) begin
            case (rx_bits[9:8])
               2'b00: slave_addr = rx_bits[7:0];
               2'b01: ram[slave_addr] = rx_bits[7:0];
               2'b10: slave_addr = rx_bits[7:0];
               default: rd_byte = ram[slave_addr];
            endcase
         end
         if (idx >= 12 + TURN && idx < 20 + TURN) MISO = rd_byte[19 + TURN - idx];
         else MISO = 1'b1;
         idx++;
      end else begin
         if (in_frame) begin
            in_frame = 1'b0;
            last_frame_len = idx;
            last_mosi = rx_bits;
            frame_count++;
            high_count = 0;
         end
         high_count++;
         MISO = 1'b1;
      end
      if (rd_valid) begin
         rd_valid_count++;
         last_rd = rd_data;
         rd_valid_pos = high_count;
      end
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      total_checks++;
      if (actual !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
      end
   endtask

   // Wait for cmd_ready, present one command for exactly one handshake.
   task automatic applyStimulus(input logic [9:0] cmd);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ready_before_cmd", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_data  = cmd;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle_reached", int'(busy), 0);
   endtask

   function automatic int expMosi(input logic [9:0] cmd);
      logic [11:0] bits;
      bits = {1'b0, cmd[9], cmd};
      return int'(bits);
   endfunction

   initial begin
      int base;
      int n;

      // reset values
      @(negedge clk);
      checkOutput("rst_ss_n", int'(SS_n), 1);
      checkOutput("rst_mosi", int'(MOSI), 0);
      checkOutput("rst_ready", int'(cmd_ready), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_rd_valid", int'(rd_valid), 0);
      checkOutput("rst_rd_data", int'(rd_data), 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_rst", int'(cmd_ready), 1);

      // write-address frame
      applyStimulus(10'h0A5);
      checkOutput("setup_ss_n", int'(SS_n), 0);
      checkOutput("setup_mosi", int'(MOSI), 0);
      checkOutput("ready_low_accept", int'(cmd_ready), 0);
      checkOutput("busy_accept", int'(busy), 1);
      waitIdle();
      checkOutput("wa_len", last_frame_len, 12);
      checkOutput("wa_mosi", int'(last_mosi), expMosi(10'h0A5));
      checkOutput("wa_no_rd", rd_valid_count, 0);
      checkOutput("wa_addr", int'(slave_addr), 8'hA5);

      // write-address then write-data, back to back
      applyStimulus(10'h012);
      applyStimulus(10'h1C3);
      waitIdle();
      checkOutput("wd_gap", last_gap, GAPC + 1);
      checkOutput("wd_len", last_frame_len, 12);
      checkOutput("wd_mosi", int'(last_mosi), expMosi(10'h1C3));
      checkOutput("wd_ram", int'(ram[8'h12]), 8'hC3);
      checkOutput("ready_in_busy", ready_violations, 0);

      // read-address then read-data
      applyStimulus(10'h212);
      applyStimulus(10'h300);
      waitIdle();
      repeat (2) @(negedge clk);
      checkOutput("rd_len", last_frame_len, 12 + TURN + 8);
      checkOutput("rd_mosi", int'(last_mosi), expMosi(10'h300));
      checkOutput("rd_pulses", rd_valid_count, 1);
      checkOutput("rd_byte", int'(last_rd), 8'hC3);
      checkOutput("rd_pulse_pos", rd_valid_pos, 1);
      checkOutput("rd_data_out", int'(rd_data), 8'hC3);

      // cmd_valid held through the whole frame and gap
      base = accept_count;
      n = 0;
      cmd_data  = 10'h055;
      cmd_valid = 1'b1;
      while (accept_count == base && n < 50) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b0;
      checkOutput("held_ready_idle", int'(cmd_ready), 1);
      repeat (3) @(negedge clk);
      checkOutput("held_accepts", accept_count - base, 1);
      checkOutput("held_addr", int'(slave_addr), 8'h55);
      checkOutput("held_ready_busy", ready_violations, 0);

      // reset during SEND bit 5
      base = frame_count;
      applyStimulus(10'h2FF);
      repeat (6) @(posedge clk);
      #2;
      checkOutput("mid_send_mosi", int'(MOSI), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("mrst_ss_n", int'(SS_n), 1);
      checkOutput("mrst_mosi", int'(MOSI), 0);
      checkOutput("mrst_busy", int'(busy), 0);
      checkOutput("mrst_rd_valid", int'(rd_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(10'h0A5);
      checkOutput("fresh_setup_ss", int'(SS_n), 0);
      checkOutput("fresh_setup_mosi", int'(MOSI), 0);
      waitIdle();
      checkOutput("fresh_len", last_frame_len, 12);
      checkOutput("fresh_mosi", int'(last_mosi), expMosi(10'h0A5));
      checkOutput("fresh_frames", frame_count - base, 2);
      checkOutput("fresh_addr", int'(slave_addr), 8'hA5);

`ifdef SPI_MASTER_SEQ_CHECK_EN
      // data command straight after reset is flagged but still sent
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      base = seq_err_count;
      applyStimulus(10'h300);
      waitIdle();
      checkOutput("seq_err_pulses", seq_err_count - base, 1);
      checkOutput("seq_err_setup", seq_err_in_setup, 1);
      checkOutput("seq_err_len", last_frame_len, 12 + TURN + 8);
      checkOutput("seq_err_mosi", int'(last_mosi), expMosi(10'h300));
      base = seq_err_count;
      applyStimulus(10'h200);
      applyStimulus(10'h300);
      waitIdle();
      checkOutput("seq_ok_pulses", seq_err_count - base, 0);
`endif

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, wanted finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Single-clock SPI master that originates 10-bit command frames toward the SPI slave + single-port RAM subsystem.
- Serialises each command on MOSI, framed by SS_n.
- For read-data commands (opcode 2'b11), it also collects the slave's 8-bit reply from MISO.
- Sits between a host/sequencer (valid/ready command interface) and the SPI pins; it is the initiator end of the existing slave protocol.

Parameters:
- TURNAROUND, 2, SS_n-low cycles between last command bit and first MISO sample on read-data frames (range 1..15).
- MIN_GAP, 1, minimum SS_n-high cycles between consecutive frames (range 1..15).

Ports:
- clk  in  1  system clock; SPI bit clock equals clk.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host presents a command.
- cmd_ready  out  1  block accepts command this cycle.
- cmd_data  in  10  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- rd_valid  out  1  one-cycle pulse: rd_data holds a valid byte.
- rd_data  out  8  byte received from MISO.
- busy  out  1  frame in progress (SS_n low or gap pending).
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered on posedge clk.
- Reset values: SS_n=1, MOSI=0, cmd_ready=0, rd_valid=0, rd_data=0, busy=0; FSM returns to IDLE.
- Handshake:
  - Command accepted on the posedge where cmd_valid && cmd_ready; cmd_data is captured into a 10-bit shift register.
  - cmd_ready=1 only in IDLE, and not in the cycle of acceptance.
  - Dropping cmd_valid without acceptance has no effect.
- FSM states: IDLE, SETUP, SEND, TURN, RECV, GAP.
- IDLE: cmd_ready=1. On accept → SETUP next cycle.
- SETUP: 1 cycle; SS_n=0, MOSI=0 (slave leaves its idle state).
- SEND: 11 cycles.
  - First bit = cmd_data[9] (slave's write/read select).
  - Next 10 bits = cmd_data[9:0], MSB first.
  - After bit 11: opcode 11 → TURN, else → GAP.
- TURN: TURNAROUND cycles with SS_n=0, MOSI=0.
- RECV: 8 cycles, MISO sampled each posedge into rd_data MSB first.
  - rd_valid pulses in the cycle after the 8th sample.
  - Then → GAP.
- GAP:
  - SS_n=1 for MIN_GAP cycles, then → IDLE.
  - busy=1 from acceptance through the final GAP cycle.
- SS_n-low frame lengths:
  - Write / rd-addr: 12 cycles.
  - Rd-data: 12+TURNAROUND+8 cycles.
- Bit/cycle counter: 4 bits, saturating to its terminal count per state; no wrap.
- Reset mid-frame: SS_n returns high asynchronously; a partial byte is discarded and rd_valid is not pulsed.
- cmd_valid asserted during GAP: held off (cmd_ready=0) until IDLE.
- Back-to-back frames are therefore separated by MIN_GAP + 1 SS_n-high cycles.

Optional Feature:
- Macro SPI_MASTER_SEQ_CHECK_EN.
- When defined:
  - Adds output seq_err (1 bit, reset 0).
  - A 2-bit last-opcode register tracks frames.
  - Accepting opcode 01 not immediately preceded by opcode 00 sets seq_err for one cycle (the acceptance+1 cycle); likewise opcode 11 not preceded by 10.
  - The frame is still transmitted unchanged.
  - After reset, the last opcode is treated as illegal-predecessor.
- When undefined: no port, no register; behaviour otherwise identical.

Decomposition:
- Package spi_master_pkg:
  - State enum (IDLE, SETUP, SEND, TURN, RECV, GAP).
  - Opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - CMD_W=10, DATA_W=8, SEND_BITS=11.
- One sub-module spi_shift_unit: loadable 10-bit PISO for MOSI plus 8-bit SIPO for MISO, with shift-enable inputs driven by the FSM.

Test Plan:
- Reset mid-SEND (rst_n low at SEND bit 5): SS_n=1 within the same cycle, MOSI=0, busy=0; next accepted command starts a fresh SETUP.
- Write-address frame: cmd_data=10'h0A5.
  - SS_n low exactly 12 cycles.
  - MOSI sequence after SETUP is 0, then 0,0,1,0,1,0,0,1,0,1.
  - No rd_valid.
- Write-address then write-data:
  - cmd 10'h012 then 10'h1C3.
  - Slave RAM address 0x12 receives 0xC3.
  - cmd_ready low from acceptance through GAP.
  - SS_n-high gap = MIN_GAP+1 = 2 cycles.
- Read-address then read-data (TURNAROUND=2):
  - cmd 10'h212 then 10'h300, with slave returning 0xC3.
  - rd_data=8'hC3 with a single-cycle rd_valid.
  - SS_n low 22 cycles on the second frame.
- Held cmd_valid during GAP: no second acceptance until IDLE; exactly one command consumed per handshake.
- With SPI_MASTER_SEQ_CHECK_EN defined:
  - Issue 10'h300 directly after reset: seq_err pulses one cycle and the frame is still sent.
  - Sequence 10'h200, 10'h300: no seq_err.
